// File: rtl/mem_bus_responder.sv
// mem_bus_responder: byte-wide ROM/RAM responder for the CPU memory bus with programmable wait states.
// Optional build macro MEMRESP_ROM_WP_EN write-protects the ROM window (writes dropped, err raised).
module mem_bus_responder #(
  parameter int WAIT_STATES = 2,
  parameter int MEM_DEPTH   = 1024,
  parameter int ROM_SIZE    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [7:0]  rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshake: a strobe (mem_read/mem_write) seen high in IDLE is accepted on that
  // rising edge; bus inputs are then ignored until the single-cycle ready pulse, which
  // carries rdata and err. A strobe still high in the IDLE cycle after ready starts a
  // new access, so the CPU drops its strobe during the ready cycle.

  localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [16:0] DEPTH_LIM = 17'(MEM_DEPTH);
  localparam logic [16:0] ROM_LIM   = 17'(ROM_SIZE);
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);
`ifdef MEMRESP_ROM_WP_EN
  localparam bit          ROM_WP    = 1'b1;
`else
  localparam bit          ROM_WP    = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [15:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic        lat_rd;
  logic        lat_wr;

  logic [7:0]  mem [MEM_DEPTH];

  logic        accept;
  logic        enter_resp;
  logic [15:0] acc_addr;
  logic [7:0]  acc_wdata;
  logic        acc_rd;
  logic        acc_wr;
  logic        acc_illegal;
  logic        acc_mapped;
  logic        acc_rom;
  logic        acc_wp_block;
  logic        acc_err;
  logic        commit;
  logic [7:0]  acc_rdata;

  assign state_dbg = state;

  // The access being resolved comes straight off the bus when the response is
  // produced on the acceptance edge (no wait states), otherwise from the latches.
  always_comb begin
    accept     = (state == S_IDLE) && (mem_read || mem_write);
    enter_resp = (accept && NO_WAIT) || ((state == S_WAIT) && (wait_cnt == 4'd0));

    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_rd    = lat_rd;
    acc_wr    = lat_wr;
    if (state == S_IDLE) begin
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_rd    = mem_read;
      acc_wr    = mem_write;
    end

    acc_illegal  = acc_rd && acc_wr;
    acc_mapped   = ({1'b0, acc_addr} < DEPTH_LIM);
    acc_rom      = ({1'b0, acc_addr} < ROM_LIM);
    acc_wp_block = ROM_WP && acc_wr && acc_rom;
    acc_err      = acc_illegal || !acc_mapped || acc_wp_block;
    commit       = enter_resp && !reset && acc_wr && !acc_err;

    acc_rdata = 8'h00;
    if (acc_rd && !acc_err) begin
      acc_rdata = mem[acc_addr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 8'h00;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      rdata     <= 8'h00;
      ready     <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= 8'h00;
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_rd    <= mem_read;
            lat_wr    <= mem_write;
            wait_cnt  <= WAIT_LOAD;
            busy      <= 1'b1;
            state     <= NO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (enter_resp) begin
        ready <= 1'b1;
        err   <= acc_err;
        rdata <= acc_rdata;
      end
    end
  end

  // Storage has no reset so preloaded images survive a bus reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[acc_addr[AW-1:0]] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed, random, back-to-back and reset-abort scenarios.
// Expected responses come from a byte-array model of the address map.
module tb_mem_bus_responder;

  localparam int WS    = 2;
  localparam int DEPTH = 1024;
  localparam int ROM   = 256;
`ifdef MEMRESP_ROM_WP_EN
  localparam bit ROM_WP = 1'b1;
`else
  localparam bit ROM_WP = 1'b0;
`endif

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [7:0]  rdata;
  logic        ready;
  logic        err;
  logic        busy;
  logic [1:0]  state_dbg;

  logic [7:0]  ref_mem [DEPTH];
  int          errors = 0;
  int          checks = 0;

  int          obs_ready_cycle;
  int          obs_ready_count;
  int          obs_busy;
  logic        obs_err;
  logic [7:0]  obs_rdata;
  logic        obs_stray;

  mem_bus_responder #(
    .WAIT_STATES(WS),
    .MEM_DEPTH  (DEPTH),
    .ROM_SIZE   (ROM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: plain address-map rules, updates ref_mem for committed writes.
  task automatic model_access(input logic rd, input logic wr, input logic [15:0] a,
                              input logic [7:0] d, output logic e, output logic [7:0] q);
    e = 1'b0;
    q = 8'h00;
    if (rd && wr) e = 1'b1;
    else if (int'(a) >= DEPTH) e = 1'b1;
    else if (rd) q = ref_mem[int'(a)];
    else if (ROM_WP && int'(a) < ROM) e = 1'b1;
    else ref_mem[int'(a)] = d;
  endtask

  // Driver: one-cycle strobe, then observe a bounded window of cycles.
  task automatic run_access(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
    obs_ready_cycle = -1;
    obs_ready_count = 0;
    obs_busy        = 0;
    obs_err         = 1'b0;
    obs_rdata       = 8'h00;
    obs_stray       = 1'b0;
    @(negedge clk);
    addr      = a;
    wdata     = d;
    mem_read  = rd;
    mem_write = wr;
    for (int k = 1; k <= WS + 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 16'($urandom);
        wdata     = 8'($urandom);
      end
      if (busy) obs_busy++;
      if (ready) begin
        obs_ready_count++;
        if (obs_ready_cycle < 0) begin
          obs_ready_cycle = k;
          obs_err         = err;
          obs_rdata       = rdata;
        end
      end else if (err || rdata != 8'h00) begin
        obs_stray = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h want=00", rdata); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    acc_t       tbl[$];
    logic       e;
    logic [7:0] q;
    tbl.push_back('{1'b1, 1'b0, 16'h0000, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 16'h0120, 8'hA7});
    tbl.push_back('{1'b1, 1'b0, 16'h0120, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 16'h0010, 8'h12});
    tbl.push_back('{1'b1, 1'b0, 16'h0010, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 16'h8000, 8'h00});
    tbl.push_back('{1'b1, 1'b1, 16'h0120, 8'h3E});
    tbl.push_back('{1'b1, 1'b0, 16'h0120, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 16'h00FF, 8'hE1});
    tbl.push_back('{1'b0, 1'b1, 16'h0100, 8'hE2});
    tbl.push_back('{1'b1, 1'b0, 16'h00FF, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 16'h0100, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 16'h03FF, 8'h6D});
    tbl.push_back('{1'b1, 1'b0, 16'h03FF, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 16'h0400, 8'h77});
    tbl.push_back('{1'b1, 1'b0, 16'h0400, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 16'h0000, 8'h00});
    foreach (tbl[i]) begin
      model_access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, e, q);
      run_access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
      checks++; if (obs_ready_cycle !== WS + 1) begin errors++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, obs_ready_cycle, WS + 1); end
      checks++; if (obs_ready_count !== 1) begin errors++; $display("FAIL dir%0d_ready_pulses got=%0d want=1", i, obs_ready_count); end
      checks++; if (obs_busy !== WS + 1) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", i, obs_busy, WS + 1); end
      checks++; if (obs_err !== e) begin errors++; $display("FAIL dir%0d_err addr=%h got=%b want=%b", i, tbl[i].a, obs_err, e); end
      checks++; if (obs_rdata !== q) begin errors++; $display("FAIL dir%0d_rdata addr=%h got=%h want=%h", i, tbl[i].a, obs_rdata, q); end
      checks++; if (obs_stray !== 1'b0) begin errors++; $display("FAIL dir%0d_stray got=%b want=0", i, obs_stray); end
    end
  endtask

  task automatic test_random();
    logic [15:0] edges [5];
    logic        rd, wr, e;
    logic [15:0] a;
    logic [7:0]  d, q;
    int          op, sel;
    edges[0] = 16'h00FF; edges[1] = 16'h0100; edges[2] = 16'h03FF;
    edges[3] = 16'h0400; edges[4] = 16'hFFFF;
    for (int n = 0; n < 40; n++) begin
      op  = $urandom_range(0, 9);
      sel = $urandom_range(0, 3);
      rd  = (op <= 5) || (op == 9);
      wr  = (op >= 6);
      d   = 8'($urandom);
      case (sel)
        0: a = 16'($urandom_range(0, ROM - 1));
        1: a = 16'($urandom_range(ROM, DEPTH - 1));
        2: a = 16'($urandom_range(DEPTH, 65535));
        default: a = edges[$urandom_range(0, 4)];
      endcase
      model_access(rd, wr, a, d, e, q);
      run_access(rd, wr, a, d);
      checks++; if (obs_ready_cycle !== WS + 1) begin errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, obs_ready_cycle, WS + 1); end
      checks++; if (obs_busy !== WS + 1) begin errors++; $display("FAIL rnd%0d_busy_cycles got=%0d want=%0d", n, obs_busy, WS + 1); end
      checks++; if (obs_err !== e) begin errors++; $display("FAIL rnd%0d_err rd=%b wr=%b addr=%h got=%b want=%b", n, rd, wr, a, obs_err, e); end
      checks++; if (obs_rdata !== q) begin errors++; $display("FAIL rnd%0d_rdata addr=%h got=%h want=%h", n, a, obs_rdata, q); end
      checks++; if (obs_stray !== 1'b0 || obs_ready_count !== 1) begin errors++; $display("FAIL rnd%0d_pulse stray=%b pulses=%0d want stray=0 pulses=1", n, obs_stray, obs_ready_count); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, a2;
    logic        e1, e2;
    logic [7:0]  q1, q2;
    int          rc[$];
    logic [7:0]  rq[$];
    logic        busy_gap;
    a1 = 16'h0120;
    a2 = 16'($urandom_range(ROM, DEPTH - 1));
    model_access(1'b1, 1'b0, a1, 8'h00, e1, q1);
    model_access(1'b1, 1'b0, a2, 8'h00, e2, q2);
    busy_gap = 1'b1;
    @(negedge clk);
    addr     = a1;
    mem_read = 1'b1;
    for (int k = 1; k <= 3 * WS + 8; k++) begin
      @(negedge clk);
      if (ready) begin
        rc.push_back(k);
        rq.push_back(rdata);
      end
      if (k == WS + 2) busy_gap = busy;
      if (k == WS + 1) addr = a2;
      if (k == WS + 3) mem_read = 1'b0;
    end
    checks++; if (rc.size() !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d want=2", rc.size()); end
    if (rc.size() >= 2) begin
      checks++; if (rc[0] !== WS + 1) begin errors++; $display("FAIL b2b_first_cycle got=%0d want=%0d", rc[0], WS + 1); end
      checks++; if (rc[1] !== 2 * WS + 3) begin errors++; $display("FAIL b2b_second_cycle got=%0d want=%0d", rc[1], 2 * WS + 3); end
      checks++; if (rq[0] !== q1) begin errors++; $display("FAIL b2b_first_rdata got=%h want=%h", rq[0], q1); end
      checks++; if (rq[1] !== q2) begin errors++; $display("FAIL b2b_second_rdata got=%h want=%h", rq[1], q2); end
    end
    checks++; if (busy_gap !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap_busy got=%b want=0", busy_gap); end
  endtask

  task automatic test_reset_mid_access();
    int          hit;
    int          pulses;
    logic [15:0] a;
    logic [7:0]  d, q;
    logic        e;
    for (int v = 0; v < 2; v++) begin
      hit = (v == 0) ? 1 : WS;
      a   = 16'h0130;
      d   = (v == 0) ? 8'h99 : 8'h5A;
      @(negedge clk);
      addr      = a;
      wdata     = d;
      mem_write = 1'b1;
      @(negedge clk);
      mem_write = 1'b0;
      repeat (hit - 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst%0d_busy got=%b want=0", v, busy); end
      checks++; if (ready !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst%0d_ready_err got=%b%b want=00", v, ready, err); end
      pulses = 0;
      repeat (WS + 3) begin
        @(negedge clk);
        if (ready) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL rst%0d_no_ready got=%0d want=0", v, pulses); end
      model_access(1'b1, 1'b0, a, 8'h00, e, q);
      run_access(1'b1, 1'b0, a, 8'h00);
      checks++; if (obs_rdata !== q || obs_err !== e) begin errors++; $display("FAIL rst%0d_mem_kept got=%h want=%h", v, obs_rdata, q); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'($urandom);
    ref_mem[16'h0000] = 8'h55;
    ref_mem[16'h0010] = 8'hC3;
    ref_mem[16'h0120] = 8'h4B;
    ref_mem[16'h0130] = 8'h3C;
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = ref_mem[i];
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
